// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU among NREQ requesters. Only one operation is in flight at a time.
// Defining ALU_ARB_FIXED_PRIO_EN replaces round-robin with fixed lowest-index-first priority.
module alu_rr_scheduler #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_sel,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y,
  output logic [4:0]        alu_sel,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  input  logic [7:0]        alu_y
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rsp_valid;
  logic [IDW-1:0]      r_rsp_id;
  logic [7:0]          r_rsp_y;
  logic [4:0]          r_alu_sel;
  logic signed [3:0]   r_alu_a;
  logic signed [3:0]   r_alu_b;
  logic                w_win_vld;
  logic [IDW-1:0]      w_win_id;
  logic [IDW-1:0]      w_cand;
  logic                w_accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest asserted index is the one left standing.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_cand = IDW'(i);
      if (req_valid[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_cand;
      end
    end
  end
`else
  logic [IDW-1:0] r_last_grant;

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_last_grant) + k) % NREQ);
      if (!w_win_vld && req_valid[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_cand;
      end
    end
  end

  // Reset value NREQ-1 makes requester 0 the first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= IDW'(NREQ - 1);
    end else if (w_accept) begin
      r_last_grant <= w_win_id;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_accept            = 1'b1;
          req_ready[w_win_id] = 1'b1;
          w_state_nxt         = S_EXEC;
        end
      end
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
      r_alu_sel   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // ALU operands move only here, so alu_y is stable through EXEC.
      if (w_accept) begin
        r_alu_sel <= req_sel[5*w_win_id +: 5];
        r_alu_a   <= req_a[4*w_win_id +: 4];
        r_alu_b   <= req_b[4*w_win_id +: 4];
        r_rsp_id  <= w_win_id;
      end
      if (r_state == S_EXEC) begin
        r_rsp_y     <= alu_y;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == S_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;
  assign alu_sel   = r_alu_sel;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a small behavioural ALU attached to the alu_* ports.
module tb_alu_rr_scheduler;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_sel;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic [4:0]        alu_sel;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [7:0]        alu_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
  );

  // Stand-in ALU: 0 = signed add, 7 = signed multiply, 10 = bitwise AND.
  function automatic logic [7:0] alu_f(input logic [4:0] s, input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] ae;
    logic signed [7:0] be;
    ae = 8'(signed'(a));
    be = 8'(signed'(b));
    case (s)
      5'd0:    return ae + be;
      5'd7:    return ae * be;
      5'd10:   return {4'b0000, a & b};
      default: return {a, b};
    endcase
  endfunction

  always_comb alu_y = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] s, input logic [3:0] a, input logic [3:0] b);
    req_sel[5*i +: 5] = s;
    req_a[4*i +: 4]   = a;
    req_b[4*i +: 4]   = b;
  endtask

  // One full transaction with rsp_ready high; drop clears the winner's valid after accept.
  task automatic run_op(input string tag, input logic [NREQ-1:0] vld, input int exp_id,
                        input logic [7:0] exp_y, input bit drop);
    req_valid = vld;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(1 << exp_id));
    tick;
    if (drop) req_valid[exp_id] = 1'b0;
    chk({tag, ".exec_nvld"}, 32'(rsp_valid), 32'd0);
    tick;
    chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, ".y"}, 32'(rsp_y), 32'(exp_y));
    tick;
    chk({tag, ".done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int exp_ids [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    req_valid = '0;
    req_sel = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    tick;
    tick;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_id", 32'(rsp_id), 32'd0);
    chk("rst.rsp_y", 32'(rsp_y), 32'd0);
    chk("rst.alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle.ready", 32'(req_ready), 32'd0);

    set_req(0, 5'b00000, 4'd3, 4'hE);
    run_op("t1", 2'b01, 0, 8'h01, 1'b1);
    set_req(1, 5'b00111, 4'h8, 4'h8);
    run_op("t2", 2'b10, 1, 8'h40, 1'b1);
    set_req(1, 5'b01010, 4'b1100, 4'b1010);
    run_op("t3", 2'b10, 1, 8'h08, 1'b1);

    set_req(0, 5'd0, 4'd1, 4'd1);
    set_req(1, 5'd10, 4'hF, 4'd3);
    for (int n = 0; n < 4; n++) begin
      run_op($sformatf("t4.%0d", n), 2'b11, exp_ids[n], (exp_ids[n] == 0) ? 8'h02 : 8'h03, 1'b0);
    end

    // Hold the response for five cycles with the consumer stalled.
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    #1;
    chk("t5.ready", 32'(req_ready), 32'b01);
    tick;
    tick;
    chk("t5.vld", 32'(rsp_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      tick;
      chk($sformatf("t5.hold_vld%0d", n), 32'(rsp_valid), 32'd1);
      chk($sformatf("t5.hold_id%0d", n), 32'(rsp_id), 32'd0);
      chk($sformatf("t5.hold_y%0d", n), 32'(rsp_y), 32'h02);
      chk($sformatf("t5.hold_rdy%0d", n), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    chk("t5.release", 32'(rsp_valid), 32'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("t5.next_ready", 32'(req_ready), 32'b01);
    tick;
    tick;
    chk("t5.next_id", 32'(rsp_id), 32'd0);
`else
    chk("t5.next_ready", 32'(req_ready), 32'b10);
    tick;
    tick;
    chk("t5.next_id", 32'(rsp_id), 32'd1);
    chk("t5.next_y", 32'(rsp_y), 32'h03);
`endif
    req_valid = '0;
    tick;

    // Reset while an operation is in EXEC.
    set_req(0, 5'd0, 4'd5, 4'd2);
    req_valid = 2'b01;
    #1;
    chk("t6.ready", 32'(req_ready), 32'b01);
    tick;
    chk("t6.alu_a", 32'(alu_a), 32'd5);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("t6.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6.alu", 32'({alu_sel, alu_a, alu_b}), 32'd0);
    chk("t6.rsp_y", 32'(rsp_y), 32'd0);
    chk("t6.rsp_id", 32'(rsp_id), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("t6.prio", 32'(req_ready), 32'b01);
    tick;
    req_valid = '0;
    chk("t6.no_result", 32'(rsp_valid), 32'd0);
    tick;
    chk("t6.vld", 32'(rsp_valid), 32'd1);
    chk("t6.id", 32'(rsp_id), 32'd0);
    chk("t6.y", 32'(rsp_y), 32'h07);
    tick;
    chk("t6.done", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
